// File: rtl/compressor_input_arbiter.sv
// Packet-granular round-robin arbiter feeding one Compressor input port from NUM_CH
// AXI-stream channels, with a per-packet beat limit, tail draining and packet status.
module compressor_input_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int DATA_W    = 256,
  parameter int MAX_BEATS = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrt_en,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     busy,
  output logic                     pkt_done,
  output logic [CH_W-1:0]          pkt_ch,
  output logic [15:0]              pkt_beats,
  output logic                     pkt_trunc
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_BEATS);

  state_t            state;
  logic [15:0]       beat_cnt;
  logic [CH_W-1:0]   next_ch;
  logic              found;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              at_limit;
  logic              acc;

  assign sel_valid = s_tvalid[grant_ch];
  assign sel_last  = s_tlast[grant_ch];
  assign sel_data  = s_data[grant_ch*DATA_W +: DATA_W];
  assign at_limit  = (beat_cnt == LAST_CNT);
  assign busy      = (state != IDLE);
  assign acc       = m_tvalid & m_tready;

  // Search starts just past the last grant so every waiting channel is served in turn.
  always_comb begin
    next_ch = grant_ch;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int k;
      k = (int'(grant_ch) + i) % NUM_CH;
      if (!found && s_tvalid[CH_W'(k)]) begin
        found   = 1'b1;
        next_ch = CH_W'(k);
      end
    end
  end

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_data   = '0;
    case (state)
      STREAM: begin
        m_data  = sel_data;
        m_tlast = sel_last | at_limit;
        if (wrt_en) begin
          m_tvalid           = sel_valid;
          s_tready[grant_ch] = m_tready;
        end
      end
      DRAIN: begin
        if (wrt_en) s_tready[grant_ch] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_ch  <= CH_W'(NUM_CH - 1);
      beat_cnt  <= '0;
      pkt_done  <= 1'b0;
      pkt_ch    <= '0;
      pkt_beats <= '0;
      pkt_trunc <= 1'b0;
    end else if (wrt_en) begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_ch <= next_ch;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (acc) begin
            if (sel_last) begin
              pkt_done  <= 1'b1;
              pkt_ch    <= grant_ch;
              pkt_beats <= beat_cnt + 16'd1;
              pkt_trunc <= 1'b0;
              beat_cnt  <= '0;
              state     <= IDLE;
            end else if (at_limit) begin
              // Limit reached without tlast: close with a forced tlast, discard the tail.
              pkt_done  <= 1'b1;
              pkt_ch    <= grant_ch;
              pkt_beats <= MAX_CNT;
              pkt_trunc <= 1'b1;
              beat_cnt  <= '0;
              state     <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compressor_input_arbiter.sv
// Scoreboard bench for compressor_input_arbiter: per-channel source queues, an expected
// beat/status queue filled at stimulus time, and a negedge monitor that pops and compares.
module tb_compressor_input_arbiter;
  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     wrt_en = 1'b0;
  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tlast;
  logic [NUM_CH-1:0]        s_tready;
  logic [DATA_W-1:0]        m_data;
  logic                     m_tvalid;
  logic                     m_tlast;
  logic                     m_tready = 1'b0;
  logic [CH_W-1:0]          grant_ch;
  logic                     busy;
  logic                     pkt_done;
  logic [CH_W-1:0]          pkt_ch;
  logic [15:0]              pkt_beats;
  logic                     pkt_trunc;

  compressor_input_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .reset(reset), .wrt_en(wrt_en),
    .s_data(s_data), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_data(m_data), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_ch(grant_ch), .busy(busy), .pkt_done(pkt_done), .pkt_ch(pkt_ch),
    .pkt_beats(pkt_beats), .pkt_trunc(pkt_trunc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W:0]    src [NUM_CH][$];
  logic [DATA_W:0]    exp_beat [$];
  logic [CH_W+16:0]   exp_pkt [$];
  int                 acc_cyc [$];
  logic [NUM_CH-1:0]  fire;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] word(input int ch, input int tag, input int k);
    return {8'(ch), 8'(tag), 16'(k)};
  endfunction

  function automatic bit src_empty();
    for (int i = 0; i < NUM_CH; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_src(input int ch, input int n, input int tag);
    for (int k = 0; k < n; k++) src[ch].push_back({(k == n - 1), word(ch, tag, k)});
  endtask

  // Packet no longer than MAX_BEATS: every beat forwarded, tlast only on the final beat.
  task automatic send_pkt(input int ch, input int n, input int tag);
    push_src(ch, n, tag);
    for (int k = 0; k < n; k++) exp_beat.push_back({(k == n - 1), word(ch, tag, k)});
    exp_pkt.push_back({CH_W'(ch), 16'(n), 1'b0});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 200 && !(exp_beat.size() == 0 && exp_pkt.size() == 0 && src_empty() && !busy)) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_complete"}, 64'(n < 200), 64'd1);
  endtask

  // Source driver: retire beats that handshook at the last edge, present the next ones.
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_data   = '0;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < NUM_CH; i++) begin
        if (fire[i] && src[i].size() > 0) void'(src[i].pop_front());
        if (src[i].size() > 0) begin
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = src[i][0][DATA_W];
          s_data[i*DATA_W +: DATA_W] = src[i][0][DATA_W-1:0];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
          s_data[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  // Monitor: compare every forwarded beat and every packet status pulse.
  initial begin
    logic [DATA_W:0]  eb;
    logic [CH_W+16:0] ep;
    fire = '0;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      if (reset && m_tvalid && m_tready) begin
        acc_cyc.push_back(cyc);
        if (exp_beat.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: actual data=%0h required=no beat", m_data);
        end else begin
          eb = exp_beat.pop_front();
          chk("beat_data", 64'(m_data), 64'(eb[DATA_W-1:0]));
          chk("beat_last", 64'(m_tlast), 64'(eb[DATA_W]));
        end
      end
      if (reset && pkt_done) begin
        if (exp_pkt.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pkt_done: actual ch=%0d beats=%0d required=no packet", pkt_ch, pkt_beats);
        end else begin
          ep = exp_pkt.pop_front();
          chk("pkt_ch", 64'(pkt_ch), 64'(ep[CH_W+16:17]));
          chk("pkt_beats", 64'(pkt_beats), 64'(ep[16:1]));
          chk("pkt_trunc", 64'(pkt_trunc), 64'(ep[0]));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant_ch"}, 64'(grant_ch), 64'(NUM_CH - 1));
    chk({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
    chk({tag, "_pkt_ch"}, 64'(pkt_ch), 64'd0);
    chk({tag, "_pkt_beats"}, 64'(pkt_beats), 64'd0);
    chk({tag, "_pkt_trunc"}, 64'(pkt_trunc), 64'd0);
  endtask

  initial begin
    int c0;
    int drain_cycles;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b1; wrt_en = 1'b1; m_tready = 1'b1;

    // Two 3-beat packets on ch0 and ch2
    @(posedge clk); #1;
    acc_cyc.delete();
    c0 = cyc;
    send_pkt(0, 3, 1);
    send_pkt(2, 3, 2);
    wait_idle("t1");
    chk("t1_beat_count", 64'(acc_cyc.size()), 64'd6);
    if (acc_cyc.size() == 6) begin
      chk("t1_cyc0", 64'(acc_cyc[0] - c0), 64'd1);
      chk("t1_cyc2", 64'(acc_cyc[2] - c0), 64'd3);
      chk("t1_cyc3", 64'(acc_cyc[3] - c0), 64'd5);
      chk("t1_cyc5", 64'(acc_cyc[5] - c0), 64'd7);
    end
    chk("t1_grant", 64'(grant_ch), 64'd2);

    // Backpressure 1,0,0,1 mid-packet on ch3
    @(posedge clk); #1;
    send_pkt(3, 3, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    @(negedge clk);
    chk("t3_hold_valid", 64'(m_tvalid), 64'd1);
    chk("t3_hold_ready", 64'(s_tready), 64'd0);
    chk("t3_hold_data", 64'(m_data), 64'(word(3, 8, 1)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_hold_data2", 64'(m_data), 64'(word(3, 8, 1)));
    chk("t3_hold_valid2", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(negedge clk);
    chk("t3_ready_follow", 64'(s_tready), 64'b1000);
    wait_idle("t3");

    // All channels valid with 1-beat packets: round-robin 0,1,2,3,0
    @(posedge clk); #1;
    acc_cyc.delete();
    send_pkt(0, 1, 3);
    send_pkt(1, 1, 4);
    send_pkt(2, 1, 5);
    send_pkt(3, 1, 6);
    send_pkt(0, 1, 7);
    wait_idle("t2");
    chk("t2_beat_count", 64'(acc_cyc.size()), 64'd5);
    if (acc_cyc.size() == 5) chk("t2_spacing", 64'(acc_cyc[4] - acc_cyc[0]), 64'd8);
    chk("t2_grant", 64'(grant_ch), 64'd0);

    // 6-beat packet on ch1 against a 4-beat limit
    @(posedge clk); #1;
    push_src(1, 6, 9);
    exp_beat.push_back({1'b0, word(1, 9, 0)});
    exp_beat.push_back({1'b0, word(1, 9, 1)});
    exp_beat.push_back({1'b0, word(1, 9, 2)});
    exp_beat.push_back({1'b1, word(1, 9, 3)});
    exp_pkt.push_back({2'd1, 16'd4, 1'b1});
    drain_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy && !m_tvalid && s_tready == 4'b0010) drain_cycles++;
    end
    chk("t4_drain_cycles", 64'(drain_cycles), 64'd2);
    wait_idle("t4");

    // Freeze for 3 cycles mid-packet; 4-beat packet exactly at the limit
    @(posedge clk); #1;
    send_pkt(2, 4, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wrt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_frz_s_tready", 64'(s_tready), 64'd0);
      chk("t6_frz_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("t6_frz_grant", 64'(grant_ch), 64'd2);
      chk("t6_frz_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    wrt_en = 1'b1;
    wait_idle("t6");

    // Reset during the second beat of a ch0 packet
    @(posedge clk); #1;
    push_src(0, 5, 11);
    push_src(1, 2, 14);
    exp_beat.push_back({1'b0, word(0, 11, 0)});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) src[i].delete();
    exp_beat.delete();
    exp_pkt.delete();
    @(negedge clk);
    check_reset_outputs("t5");
    @(posedge clk); #1;
    reset = 1'b1;
    send_pkt(0, 2, 12);
    send_pkt(1, 1, 13);
    wait_idle("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=time limit reached required=bench completion");
    $fatal(1, "timeout");
  end

endmodule
